fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Sequencer placed in front of and behind fft_N_point_core.
- Collects a serial sample stream into N_POINT-word frames using valid/ready, then launches each frame into the core's parallel input.
- Counts the core's fixed pipeline latency, captures the parallel result and streams it out serially with backpressure.
- One frame is in flight in the core at a time. The input buffer can fill the next frame while the core is running or the output is draining.

Parameters:
- DATA_WIDTH, 16, sample and result word width.
- N_POINT, 16, frame length; must be a power of 2, at least 2.
- CORE_LATENCY, 4, number of clock edges from a change on core_x to a stable core_y (one per butterfly stage); must be at least 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input buffer can accept a sample.
- s_data  in  DATA_WIDTH  input sample.
- s_last  in  1  marks the final sample of a frame.
- core_x  out  DATA_WIDTH x N_POINT  registered frame driven to the core input.
- core_y  in  DATA_WIDTH x N_POINT  core output.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the output word.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks the final output word of a frame (index N_POINT-1).
- busy  out  1  high when core FSM is not IDLE or in_full=1.
- frame_err  out  1  one-cycle pulse when a malformed input frame is discarded.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Registers: wr_idx=0, in_full=0, core FSM=IDLE, cnt=0, rd_idx=0.
  - Outputs: s_ready=1, m_valid=0, m_last=0, frame_err=0, busy=0.
  - core_x and m_data/out_buf are all zeros.
  - Reset mid-frame abandons all partial and in-flight data; no output follows reset.
- Input side:
  - s_ready = !in_full.
  - On a handshake (s_valid & s_ready), write in_buf[wr_idx] = s_data.
  - If wr_idx==N_POINT-1 and s_last=1: set in_full=1 and wr_idx=0.
  - If s_last=1 and wr_idx!=N_POINT-1: the frame is short. Discard it, set wr_idx=0 and pulse frame_err the next cycle.
  - If wr_idx==N_POINT-1 and s_last=0: the frame is long. Discard it, set wr_idx=0 and pulse frame_err.
  - Otherwise increment wr_idx.
- Core FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - When in_full=1, at the next edge: core_x <= in_buf, in_full <= 0, cnt <= 0, go to RUN. This edge is the launch edge.
  - s_ready is therefore 1 again in the cycle after launch.
- RUN:
  - core_x is held stable.
  - cnt increments each cycle.
  - When cnt==CORE_LATENCY, at that edge: out_buf <= core_y, rd_idx <= 0, go to DRAIN.
  - Result: m_valid first asserts CORE_LATENCY+1 cycles after the launch edge.
- DRAIN:
  - m_valid=1, m_data=out_buf[rd_idx], m_last=(rd_idx==N_POINT-1).
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - On each handshake rd_idx increments.
  - The handshake with m_last=1 returns the FSM to IDLE.
  - If in_full=1 at that point, the next launch occurs one edge later. There are no back-to-back launches without passing through IDLE.
- Input filling continues during RUN and DRAIN. Once in_full=1, input stalls (s_ready=0) until the next launch.
- cnt width is clog2(CORE_LATENCY+1). wr_idx and rd_idx width is clog2(N_POINT). Indices wrap to 0 only by explicit reset-to-0, never by overflow.
- No arithmetic is performed on data; words pass through bit-exact.

Decomposition:
- Package fft_pkg holds:
  - the core FSM state enum (IDLE, RUN, DRAIN);
  - localparam functions for index widths (IDX_W = $clog2(N_POINT));
  - the frame array typedef (DATA_WIDTH x N_POINT).
- One sub-module, fft_in_collector, contains in_buf, wr_idx, in_full, the s_last checking and frame_err. It exposes in_full, the frame and a launch-ack input.
- The top level holds the core FSM, cnt, out_buf and the serializer.

Test Plan:
- Bench setup: the core is replaced by a model delaying core_x by CORE_LATENCY registers with y[i]=x[i]+1.
- Single frame: send 0..15 with s_last on 15 and m_ready=1.
  - Launch on the edge after the 16th handshake; m_valid rises 5 cycles later.
  - m_data = 1..16; m_last only on word 16; busy falls after the last handshake.
- Backpressure: same frame with m_ready toggling 1,0,0,1 repeating.
  - m_data and m_last stay stable while stalled; exactly 16 words out, in order.
- Overlap: send frame A (0..15) and immediately frame B (100..115) with m_ready=0 for 40 cycles.
  - s_ready goes low after B fills.
  - After A drains, B launches 1 cycle later; output is 1..16 then 101..116.
- Framing errors: s_last on the 5th sample.
  - frame_err pulses once; no output; the next good frame of 16 is processed normally.
  - A 16th sample without s_last also produces frame_err and no output.
- Reset mid-operation: assert rst_n=0 during RUN and again during DRAIN (rd_idx=7).
  - Outputs immediately take reset values; no residual words are emitted after release.
  - A fresh frame then works as in the single-frame case.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type, frame type and width helper for the FFT frame sequencer
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int FFT_N_POINT    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } core_state_t;

  typedef logic [FFT_N_POINT-1:0][FFT_DATA_WIDTH-1:0] frame_t;

  // Index width for an n-entry buffer; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_in_collector.sv
// rtl/fft_in_collector.sv - gathers serial samples into one frame and rejects malformed frames
module fft_in_collector
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINT    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [DATA_WIDTH-1:0]                i_data,
  input  logic                                 i_last,
  input  logic                                 i_launch,
  output logic                                 o_full,
  output logic [N_POINT-1:0][DATA_WIDTH-1:0]   o_frame,
  output logic                                 o_frame_err
);

  localparam int                IDX_W    = idx_w(N_POINT);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_POINT - 1);

  logic [N_POINT-1:0][DATA_WIDTH-1:0] r_in_buf;
  logic [IDX_W-1:0]                   r_wr_idx;
  logic                               r_in_full;
  logic                               r_frame_err;
  logic                               w_hs;
  logic                               w_at_end;

  assign w_hs        = i_valid && !r_in_full;
  assign w_at_end    = (r_wr_idx == LAST_IDX);
  assign o_ready     = !r_in_full;
  assign o_full      = r_in_full;
  assign o_frame     = r_in_buf;
  assign o_frame_err = r_frame_err;

  // Write accepted samples, close a frame only when s_last lands exactly on the final slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_buf    <= '0;
      r_wr_idx    <= '0;
      r_in_full   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (i_launch) begin
        r_in_full <= 1'b0;
      end
      if (w_hs) begin
        r_in_buf[r_wr_idx] <= i_data;
        if (i_last && w_at_end) begin
          r_in_full <= 1'b1;
          r_wr_idx  <= '0;
        end else if (i_last || w_at_end) begin
          // Short or long frame: drop what was gathered and restart at slot 0.
          r_wr_idx    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames a sample stream into the FFT core and serializes its result
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int N_POINT      = 16,
  parameter int CORE_LATENCY = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_WIDTH-1:0]                s_data,
  input  logic                                 s_last,
  output logic [N_POINT-1:0][DATA_WIDTH-1:0]   core_x,
  input  logic [N_POINT-1:0][DATA_WIDTH-1:0]   core_y,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic                                 m_last,
  output logic                                 busy,
  output logic                                 frame_err
);

  localparam int                IDX_W    = idx_w(N_POINT);
  localparam int                CNT_W    = $clog2(CORE_LATENCY + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_POINT - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(CORE_LATENCY);

  core_state_t                        r_state;
  logic [CNT_W-1:0]                   r_cnt;
  logic [N_POINT-1:0][DATA_WIDTH-1:0] r_core_x;
  logic [N_POINT-1:0][DATA_WIDTH-1:0] r_out_buf;
  logic [IDX_W-1:0]                   r_rd_idx;
  logic                               r_m_valid;
  logic [DATA_WIDTH-1:0]              r_m_data;
  logic                               r_m_last;

  logic                               w_in_full;
  logic [N_POINT-1:0][DATA_WIDTH-1:0] w_frame;
  logic                               w_launch;
  logic                               w_m_hs;
  logic [IDX_W-1:0]                   w_rd_next;

  // A frame is only handed over from IDLE, so the core never sees back-to-back launches.
  assign w_launch  = (r_state == IDLE) && w_in_full;
  assign w_m_hs    = r_m_valid && m_ready;
  assign w_rd_next = r_rd_idx + 1'b1;

  fft_in_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_POINT    (N_POINT)
  ) u_in_collector (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (s_valid),
    .o_ready     (s_ready),
    .i_data      (s_data),
    .i_last      (s_last),
    .i_launch    (w_launch),
    .o_full      (w_in_full),
    .o_frame     (w_frame),
    .o_frame_err (frame_err)
  );

  assign core_x  = r_core_x;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign busy    = (r_state != IDLE) || w_in_full;

  // Core sequencer: launch a full frame, wait out the core latency, then stream the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_core_x  <= '0;
      r_out_buf <= '0;
      r_rd_idx  <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_full) begin
            r_core_x <= w_frame;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (r_cnt == CNT_DONE) begin
            r_out_buf <= core_y;
            r_rd_idx  <= '0;
            r_m_valid <= 1'b1;
            r_m_data  <= core_y[0];
            r_m_last  <= 1'b0;
            r_state   <= DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (w_m_hs) begin
            if (r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_rd_idx <= w_rd_next;
              r_m_data <= r_out_buf[w_rd_next];
              r_m_last <= (w_rd_next == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed self-checking bench for fft_frame_ctrl
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int DW  = 16;
  localparam int NP  = 16;
  localparam int LAT = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic          m_last;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          frame_err;
  frame_t        core_x;
  frame_t        core_y;
  frame_t        pipe [LAT];

  int n_pass   = 0;
  int n_total  = 0;
  int cyc      = 0;
  int err_cnt  = 0;
  int timeouts = 0;

  logic [DW:0]   out_q [$];
  int            out_cyc [$];
  logic          prev_stall = 1'b0;
  logic          prev_rst   = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .DATA_WIDTH   (DW),
    .N_POINT      (NP),
    .CORE_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .core_x    (core_x),
    .core_y    (core_y),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Stand-in core: LAT register stages, each result word is its input word plus one.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NP; i++) pipe[0][i] <= core_x[i] + 16'd1;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign core_y = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitor: record handshakes, count error pulses, hold-stable check while stalled.
  always @(negedge clk) begin
    if (rst_n && prev_rst && prev_stall) begin
      check("stall_valid", {31'd0, m_valid}, 32'd1);
      check("stall_data", {16'd0, m_data}, {16'd0, prev_data});
      check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
    end
    if (rst_n && m_valid && m_ready) begin
      out_q.push_back({m_last, m_data});
      out_cyc.push_back(cyc);
    end
    if (frame_err) err_cnt++;
    prev_stall = rst_n && m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_rst   = rst_n;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) timeouts++;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) send(DW'(base + i), (i == last_idx));
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    while ((busy || m_valid) && t < max) begin
      step();
      t++;
    end
    if (t >= max) timeouts++;
  endtask

  task automatic wait_valid(input int max);
    int t;
    t = 0;
    while (!m_valid && t < max) begin
      step();
      t++;
    end
    if (t >= max) timeouts++;
  endtask

  task automatic check_frame(input string tag, input int first, input int base);
    logic [DW:0] e;
    for (int i = 0; i < NP; i++) begin
      e = {(i == NP - 1), DW'(base + 1 + i)};
      check(tag, {15'd0, out_q[first + i]}, {15'd0, e});
    end
  endtask

  initial begin
    int lat;
    int e0;

    // Reset state
    rst_n = 1'b0;
    steps(3);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    check("rst_core_x", {31'd0, (core_x == '0)}, 32'd1);
    rst_n = 1'b1;
    step();

    // Single frame, m_ready always high
    m_ready = 1'b1;
    send_frame(0, NP, NP - 1);
    check("t1_s_ready_full", {31'd0, s_ready}, 32'd0);
    check("t1_busy_full", {31'd0, busy}, 32'd1);
    step();
    check("t1_s_ready_after_launch", {31'd0, s_ready}, 32'd1);
    lat = 1;
    while (!m_valid && lat < 50) begin
      step();
      lat++;
    end
    check("t1_latency", lat, 32'd6);
    check("t1_first_data", {16'd0, m_data}, 32'd1);
    steps(15);
    check("t1_busy_before_last", {31'd0, busy}, 32'd1);
    step();
    check("t1_busy_after_last", {31'd0, busy}, 32'd0);
    check("t1_m_valid_after_last", {31'd0, m_valid}, 32'd0);
    check("t1_count", out_q.size(), 32'd16);
    if (out_q.size() == NP) check_frame("t1_word", 0, 0);

    // Backpressure with m_ready pattern 1,0,0,1
    out_q.delete();
    send_frame(0, NP, NP - 1);
    for (int c = 0; c < 400 && !(out_q.size() == NP && !busy && !m_valid); c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      step();
    end
    m_ready = 1'b1;
    step();
    check("t2_count", out_q.size(), 32'd16);
    if (out_q.size() == NP) check_frame("t2_word", 0, 0);

    // Overlap: frame B fills while A is held in the output stage
    out_q.delete();
    out_cyc.delete();
    m_ready = 1'b0;
    send_frame(0, NP, NP - 1);
    send_frame(100, NP, NP - 1);
    check("t3_s_ready_b_full", {31'd0, s_ready}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    steps(8);
    check("t3_a_held_valid", {31'd0, m_valid}, 32'd1);
    check("t3_a_held_data", {16'd0, m_data}, 32'd1);
    check("t3_s_ready_still_low", {31'd0, s_ready}, 32'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 300 && !(out_q.size() == 2 * NP && !busy && !m_valid); c++) step();
    check("t3_count", out_q.size(), 32'd32);
    if (out_q.size() == 2 * NP) begin
      check_frame("t3_word_a", 0, 0);
      check_frame("t3_word_b", NP, 100);
      check("t3_launch_gap", out_cyc[NP] - out_cyc[NP - 1], 32'd7);
    end

    // Framing errors: short frame, then a good frame, then a long frame
    out_q.delete();
    e0 = err_cnt;
    send_frame(50, 5, 4);
    steps(3);
    check("t4_short_err", err_cnt - e0, 32'd1);
    check("t4_short_no_out", out_q.size(), 32'd0);
    check("t4_short_busy", {31'd0, busy}, 32'd0);
    check("t4_short_s_ready", {31'd0, s_ready}, 32'd1);
    send_frame(200, NP, NP - 1);
    wait_idle(100);
    step();
    check("t4_good_count", out_q.size(), 32'd16);
    if (out_q.size() == NP) check_frame("t4_good_word", 0, 200);
    out_q.delete();
    send_frame(300, NP, -1);
    steps(10);
    check("t4_long_err", err_cnt - e0, 32'd2);
    check("t4_long_no_out", out_q.size(), 32'd0);
    check("t4_long_busy", {31'd0, busy}, 32'd0);

    // Reset while the core is running
    out_q.delete();
    send_frame(0, NP, NP - 1);
    steps(2);
    rst_n = 1'b0;
    #1;
    check("t5_run_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("t5_run_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_run_rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("t5_run_rst_core_x", {31'd0, (core_x == '0)}, 32'd1);
    steps(2);
    rst_n = 1'b1;
    steps(30);
    check("t5_run_rst_no_out", out_q.size(), 32'd0);

    // Reset while draining at rd_idx 7
    m_ready = 1'b0;
    send_frame(0, NP, NP - 1);
    wait_valid(100);
    m_ready = 1'b1;
    steps(7);
    m_ready = 1'b0;
    check("t5_drain_data_idx7", {16'd0, m_data}, 32'd8);
    check("t5_drain_seen", out_q.size(), 32'd7);
    rst_n = 1'b0;
    #1;
    check("t5_drain_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("t5_drain_rst_m_data", {16'd0, m_data}, 32'd0);
    check("t5_drain_rst_m_last", {31'd0, m_last}, 32'd0);
    check("t5_drain_rst_busy", {31'd0, busy}, 32'd0);
    steps(2);
    rst_n = 1'b1;
    out_q.delete();
    steps(30);
    check("t5_drain_rst_no_out", out_q.size(), 32'd0);

    // Fresh frame after reset behaves like the single-frame case
    m_ready = 1'b1;
    send_frame(0, NP, NP - 1);
    wait_idle(100);
    step();
    check("t5_fresh_count", out_q.size(), 32'd16);
    if (out_q.size() == NP) check_frame("t5_fresh_word", 0, 0);

    check("no_timeouts", timeouts, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
